// File: rtl/sevenseg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: segment bit positions,
// the hex-to-segment glyph table and the scan state encoding.
package sevenseg_scan_ctrl_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Entry n is the active-high segment pattern for hex digit n; entry 15 sits at the MSB.
  localparam logic [15:0][7:0] HEX_SEG_TBL = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  typedef enum logic [1:0] {OFF, GUARD, SHOW} state_t;

endpackage

// File: rtl/sevenseg_scan_ctrl_hex.sv
// Hex nibble to seven-segment glyph, purely combinational.
// The decimal point is always driven low.
module hex_to_sevenseg
  import sevenseg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg         = HEX_SEG_TBL[nibble];
    seg[SEG_DP] = 1'b0;
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed hex display scanner with a one-cycle dead-time guard between digits.
// Outputs are registered; a new value is only ever shown from a frame boundary onward.
module sevenseg_scan_ctrl
  import sevenseg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
)
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  state_t          state, nxt_state;
  logic [IW-1:0]   idx, nxt_idx;
  logic [CW-1:0]   cnt, nxt_cnt;
  logic [DW-1:0]   disp_reg, nxt_disp;
  logic [DW-1:0]   pend_reg, nxt_pend;
  logic            pend_valid, nxt_pend_valid;
  logic            have_data, nxt_have_data;
  logic            promote;

  logic [3:0]      nib;
  logic [7:0]      dec_seg;
  logic [DW-1:0]   upper;
  logic            lz_blank;
  logic [NUM_DIGITS-1:0] an_d;
  logic [7:0]      seg_d;
  logic            fd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OFF;
      idx        <= '0;
      cnt        <= '0;
      disp_reg   <= '0;
      pend_reg   <= '0;
      pend_valid <= 1'b0;
      have_data  <= 1'b0;
      seg        <= '0;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      idx        <= nxt_idx;
      cnt        <= nxt_cnt;
      disp_reg   <= nxt_disp;
      pend_reg   <= nxt_pend;
      pend_valid <= nxt_pend_valid;
      have_data  <= nxt_have_data;
      seg        <= seg_d;
      an         <= an_d;
      frame_done <= fd_d;
    end
  end

  // Frame end or leaving the scan is the only point where the shown value may change.
  assign promote = (state != OFF) &&
                   (!en || (state == SHOW && cnt == CNT_LAST && idx == IDX_LAST));

  always_comb begin
    nxt_state      = state;
    nxt_idx        = idx;
    nxt_cnt        = cnt;
    nxt_disp       = disp_reg;
    nxt_pend       = pend_reg;
    nxt_pend_valid = pend_valid;
    nxt_have_data  = have_data;

    if (state == OFF) begin
      if (load) begin
        nxt_disp      = value;
        nxt_have_data = 1'b1;
      end
    end else if (promote) begin
      if (load)            nxt_disp = value;
      else if (pend_valid) nxt_disp = pend_reg;
      nxt_pend_valid = 1'b0;
    end else if (load) begin
      nxt_pend       = value;
      nxt_pend_valid = 1'b1;
    end

    if (!en) begin
      nxt_state = OFF;
      nxt_idx   = '0;
      nxt_cnt   = '0;
    end else begin
      unique case (state)
        OFF: begin
          if (have_data || load) begin
            nxt_state = GUARD;
            nxt_idx   = '0;
            nxt_cnt   = '0;
          end
        end
        GUARD: begin
          nxt_state = SHOW;
          nxt_cnt   = '0;
        end
        SHOW: begin
          if (cnt == CNT_LAST) begin
            nxt_state = GUARD;
            nxt_cnt   = '0;
            nxt_idx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        default: begin
          nxt_state = OFF;
          nxt_idx   = '0;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  // Registered outputs are computed from the next-state view so they line up with the state.
  always_comb begin
    nib  = '0;
    an_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (nxt_idx == IW'(i)) begin
        nib     = nxt_disp[4*i +: 4];
        an_d[i] = 1'b1;
      end
    end
    upper    = nxt_disp >> {nxt_idx, 2'b00};
    lz_blank = blank_lz && (nxt_idx != '0) && (upper == '0);
    if (nxt_state != SHOW) an_d = '0;
    seg_d = (nxt_state == SHOW && !lz_blank) ? dec_seg : 8'h00;
    fd_d  = (nxt_state == SHOW) && (nxt_idx == IDX_LAST) && (nxt_cnt == CNT_LAST);
  end

  hex_to_sevenseg u_dec (
    .nibble (nib),
    .seg    (dec_seg)
  );

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Randomized and directed checks of the scan controller against a frame-position model.
module tb_sevenseg_scan_ctrl;

  localparam int N = 2;
  localparam int R = 4;
  localparam int P = N * (R + 1);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         load;
  logic [7:0]   value;
  logic         blank_lz;
  logic [7:0]   seg;
  logic [N-1:0] an;
  logic         frame_done;

  int vectors     = 0;
  int miscompares = 0;

  // Model: display on/off, position inside the frame, displayed and pending values.
  bit         m_on, m_have, m_pv, m_blz;
  int         m_pos;
  logic [7:0] m_disp, m_pend;
  logic [7:0] tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                           8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  function automatic logic [7:0] exp_seg();
    int slot;
    logic [7:0] rest;
    if (!m_on || (m_pos % (R + 1)) == 0) return 8'h00;
    slot = m_pos / (R + 1);
    rest = m_disp >> (4 * slot);
    if (m_blz && slot > 0 && rest == 8'h00) return 8'h00;
    return tbl[rest[3:0]];
  endfunction

  function automatic logic [N-1:0] exp_an();
    logic [N-1:0] a;
    a = '0;
    if (m_on && (m_pos % (R + 1)) != 0) a[m_pos / (R + 1)] = 1'b1;
    return a;
  endfunction

  function automatic logic exp_fd();
    return m_on && m_pos == P - 1;
  endfunction

  task automatic model_reset();
    m_on = 0; m_have = 0; m_pv = 0; m_blz = 0; m_pos = 0;
    m_disp = 8'h00; m_pend = 8'h00;
  endtask

  task automatic model_step();
    m_blz = blank_lz;
    if (!en) begin
      if (m_on) begin
        if (load) m_disp = value;
        else if (m_pv) m_disp = m_pend;
        m_pv = 0;
      end else if (load) begin
        m_disp = value; m_have = 1;
      end
      m_on = 0; m_pos = 0;
    end else if (!m_on) begin
      if (load) begin m_disp = value; m_have = 1; end
      if (m_have) begin m_on = 1; m_pos = 0; end
    end else if (m_pos == P - 1) begin
      if (load) m_disp = value;
      else if (m_pv) m_disp = m_pend;
      m_pv = 0; m_pos = 0;
    end else begin
      if (load) begin m_pend = value; m_pv = 1; end
      m_pos++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic e, input logic l, input logic [7:0] v, input logic b);
    en = e; load = l; value = v; blank_lz = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0);
    model_reset();
    #1;
    vectors++;
    if ({an, seg, frame_done} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset: an=%b seg=%h fd=%b, want all zero", an, seg, frame_done);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({an, seg, frame_done} !== {exp_an(), exp_seg(), exp_fd()}) begin
        miscompares++;
        $display("FAIL reset_idle: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                 an, seg, frame_done, exp_an(), exp_seg(), exp_fd());
      end
    end
  endtask

  task automatic test_first_display();
    int fd_cnt = 0;
    drive(1, 1, 8'h94, 0);
    tick();
    drive(1, 0, 8'h00, 0);
    vectors++;
    if (an !== 2'b00 || seg !== 8'h00) begin
      miscompares++;
      $display("FAIL first_guard: an=%b seg=%h, want an=00 seg=00", an, seg);
    end
    tick();
    vectors++;
    if (an !== 2'b01 || seg !== 8'b01100110) begin
      miscompares++;
      $display("FAIL first_digit0: an=%b seg=%h, want an=01 seg=66", an, seg);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (frame_done) fd_cnt++;
      vectors++;
      if ({an, seg, frame_done} !== {exp_an(), exp_seg(), exp_fd()}) begin
        miscompares++;
        $display("FAIL first_scan cyc %0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                 i, an, seg, frame_done, exp_an(), exp_seg(), exp_fd());
      end
    end
    vectors++;
    if (fd_cnt != 2) begin
      miscompares++;
      $display("FAIL frame_done_count: got %0d pulses in 20 cycles, want 2", fd_cnt);
    end
  endtask

  task automatic test_pending();
    int guard_cnt;
    // loads at chosen frame positions: mid digit 0, then two in one frame, then on frame_done
    logic [7:0] vals [4] = '{8'h21, 8'h33, 8'h57, 8'hAB};
    int         poss [4] = '{2, 1, 7, P - 1};
    for (int k = 0; k < 4; k++) begin
      guard_cnt = 0;
      while (!(m_on && m_pos == poss[k]) && guard_cnt < 50) begin
        tick();
        guard_cnt++;
      end
      vectors++;
      if (guard_cnt >= 50) begin
        miscompares++;
        $display("FAIL pending_wait %0d: position %0d not reached", k, poss[k]);
      end
      drive(1, 1, vals[k], 0);
      tick();
      drive(1, 0, 8'h00, 0);
      for (int i = 0; i < (k == 1 ? 3 : 2 * P); i++) begin
        vectors++;
        if ({an, seg, frame_done} !== {exp_an(), exp_seg(), exp_fd()}) begin
          miscompares++;
          $display("FAIL pending %0d cyc %0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                   k, i, an, seg, frame_done, exp_an(), exp_seg(), exp_fd());
        end
        tick();
      end
    end
  endtask

  task automatic test_blank();
    logic [7:0] vals [2] = '{8'h07, 8'h00};
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, vals[k], 1);
      tick();
      drive(1, 0, 8'h00, 1);
      for (int i = 0; i < 3 * P; i++) begin
        tick();
        vectors++;
        if ({an, seg, frame_done} !== {exp_an(), exp_seg(), exp_fd()}) begin
          miscompares++;
          $display("FAIL blank %0d cyc %0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                   k, i, an, seg, frame_done, exp_an(), exp_seg(), exp_fd());
        end
      end
    end
    drive(1, 0, 8'h00, 0);
  endtask

  task automatic test_enable();
    for (int i = 0; i < 3; i++) tick();
    drive(0, 0, 8'h00, 0);
    tick();
    vectors++;
    if (an !== 2'b00 || seg !== 8'h00) begin
      miscompares++;
      $display("FAIL en_drop: an=%b seg=%h, want an=00 seg=00", an, seg);
    end
    drive(1, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if ({an, seg, frame_done} !== {exp_an(), exp_seg(), exp_fd()}) begin
        miscompares++;
        $display("FAIL en_rise cyc %0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                 i, an, seg, frame_done, exp_an(), exp_seg(), exp_fd());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({an, seg, frame_done} !== 11'd0) begin
      miscompares++;
      $display("FAIL async_reset: an=%b seg=%h fd=%b, want all zero", an, seg, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if ({an, seg, frame_done} !== {exp_an(), exp_seg(), exp_fd()}) begin
        miscompares++;
        $display("FAIL post_reset_off cyc %0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                 i, an, seg, frame_done, exp_an(), exp_seg(), exp_fd());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 10),
            8'($urandom()), ($urandom_range(0, 3) == 0));
      tick();
      vectors++;
      if ({an, seg, frame_done} !== {exp_an(), exp_seg(), exp_fd()}) begin
        miscompares++;
        $display("FAIL random cyc %0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                 i, an, seg, frame_done, exp_an(), exp_seg(), exp_fd());
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_display();
    test_pending();
    test_blank();
    test_enable();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
